// File: rtl/somador_serial_8bits.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first, one bit per clock.
// start/busy/done handshake; s and the flags are registered and only change at the final load.
module somador_serial_8bits #(
  parameter int unsigned LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [LARGURA-1:0] s,
  output logic               cout,
  output logic               ov,
  output logic               neg,
  output logic               zero
);

  localparam int unsigned CW = $clog2(LARGURA) + 1;
  localparam logic [CW-1:0] CntLast = CW'(LARGURA - 1);

  typedef enum logic [1:0] {Idle, Soma, Fim} state_t;

  state_t             state;
  logic [LARGURA-1:0] reg_a;
  logic [LARGURA-1:0] reg_b;
  logic [LARGURA-1:0] sum_sr;
  logic               carry;
  logic [CW-1:0]      cnt;

  logic               bit_s;
  logic               carry_n;
  logic [LARGURA-1:0] sum_full;

  // Single full-adder cell working on the current LSBs.
  always_comb begin
    bit_s    = reg_a[0] ^ reg_b[0] ^ carry;
    carry_n  = (reg_a[0] & reg_b[0]) | (carry & (reg_a[0] ^ reg_b[0]));
    sum_full = {bit_s, sum_sr[LARGURA-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= Idle;
      reg_a  <= '0;
      reg_b  <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      s      <= '0;
      cout   <= 1'b0;
      ov     <= 1'b0;
      neg    <= 1'b0;
      zero   <= 1'b1;
    end else begin
      unique case (state)
        Idle: begin
          if (start) begin
            reg_a <= a;
            reg_b <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= Soma;
          end
        end
        Soma: begin
          reg_a  <= reg_a >> 1;
          reg_b  <= reg_b >> 1;
          sum_sr <= sum_full;
          carry  <= carry_n;
          cnt    <= cnt + 1'b1;
          if (cnt == CntLast) begin
            // carry still holds the carry into the MSB here, carry_n the carry out of it.
            s     <= sum_full;
            cout  <= carry_n;
            ov    <= carry ^ carry_n;
            neg   <= sum_full[LARGURA-1];
            zero  <= (sum_full == '0);
            done  <= 1'b1;
            state <= Fim;
          end
        end
        Fim: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= Idle;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial_8bits.sv
// Self-checking bench: directed table, random operands against an arithmetic model,
// and hand-written handshake and asynchronous-reset sequences.
module tb_somador_serial_8bits;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout, ov, neg, zero;
  logic [7:0] s;

  int vectors = 0;
  int miscompares = 0;

  somador_serial_8bits dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .s    (s),
    .cout (cout),
    .ov   (ov),
    .neg  (neg),
    .zero (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       ng;
    logic       z;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {co,ov,ng,z,s} from plain integer arithmetic.
  function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    int unsigned t;
    logic [7:0] r;
    logic o;
    t = int'(x) + int'(y) + int'(c);
    r = t[7:0];
    o = (x[7] == y[7]) && (r[7] != x[7]);
    return {t[8], o, r[7], (r == 8'h00), r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check latency, busy length, held result and final result.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                        input logic [11:0] exp, input string tag);
    int cycles;
    int busy_cnt;
    logic held_ok;
    logic [11:0] prev;
    prev = {cout, ov, neg, zero, s};
    held_ok = 1'b1;
    a = x; b = y; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~x; b = ~y; cin = ~c;
    busy_cnt = busy ? 1 : 0;
    cycles = 0;
    while (cycles < 20) begin
      tick();
      cycles++;
      if (busy) busy_cnt++;
      if (done) break;
      if ({cout, ov, neg, zero, s} !== prev) held_ok = 1'b0;
    end
    chk({tag, " latency"}, cycles, 8);
    chk({tag, " held"}, held_ok, 1);
    chk({tag, " s"}, s, exp[7:0]);
    chk({tag, " flags co/ov/ng/z"}, {cout, ov, neg, zero}, exp[11:8]);
    tick();
    chk({tag, " busy len"}, busy_cnt, 9);
    chk({tag, " end done/busy"}, {done, busy}, 2'b00);
  endtask

  initial begin
    int ndone;
    int nbusy;
    int cycles;
    logic [7:0] ra, rb;
    logic rc;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'hC8, 8'h14, 1'b0, 8'hDC, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state, checked before any clock edge reaches the design.
    #1 rst = 1'b1;
    #2;
    chk("reset busy/done", {busy, done}, 2'b00);
    chk("reset s", s, 8'h00);
    chk("reset co/ov/ng/z", {cout, ov, neg, zero}, 4'b0001);
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].ci,
             {tbl[i].co, tbl[i].ov, tbl[i].ng, tbl[i].z, tbl[i].s}, $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, model(ra, rb, rc), $sformatf("rnd%0d %h+%h+%0d", i, ra, rb, rc));
    end

    // Requests during SOMA and FIM are ignored.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    cycles = 0;
    while (cycles < 20 && ndone == 0) begin
      tick();
      cycles++;
      if (done) ndone++;
    end
    chk("hs s", s, 8'h30);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hs after fim done/busy", {done, busy}, 2'b00);
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("hs done count", ndone, 1);
    chk("hs no second busy", nbusy, 0);

    // start held high: re-accepted on the first IDLE edge after done.
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    tick();
    cycles = 0;
    while (cycles < 20 && !done) begin
      tick();
      cycles++;
    end
    chk("held start first latency", cycles, 8);
    chk("held start first s", s, 8'h07);
    a = 8'h09; b = 8'h01;
    tick();
    chk("held start idle busy", busy, 0);
    tick();
    chk("held start reaccept busy", busy, 1);
    start = 1'b0;
    cycles = 0;
    while (cycles < 20 && !done) begin
      tick();
      cycles++;
    end
    chk("held start second latency", cycles, 8);
    chk("held start second s", s, 8'h0A);
    tick();

    // Asynchronous reset mid-operation.
    a = 8'h7F; b = 8'h7F; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("rst busy/done", {busy, done}, 2'b00);
    chk("rst s", s, 8'h00);
    chk("rst zero", zero, 1);
    tick();
    #2 rst = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("rst no done", ndone, 0);
    chk("rst no busy", nbusy, 0);
    run_op(8'h01, 8'h01, 1'b0, model(8'h01, 8'h01, 1'b0), "post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/somador_serial_8bits.md
Name: somador_serial_8bits

Overview:
- Multi-cycle, bit-serial 8-bit adder. It is the addition counterpart of the team's combinational two's-complement subtractor.
- It uses a single full-adder cell and a carry flip-flop, and processes one bit per clock, LSB first.
- It exposes the same result flags as the subtractor: cout, ov and neg, plus zero.
- It sits in the ULA datapath where area matters more than latency. A start/busy/done handshake lets the ULA control FSM sequence it.

Parameters:
- LARGURA, 8, operand/result width in bits. Only 8 is verified; the bit counter is sized ceil(log2(LARGURA))+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  8  operand A; sampled on the accepting edge
- b  input  8  operand B; sampled on the accepting edge
- cin  input  1  carry in; sampled on the accepting edge
- busy  output  1  high from the accepting edge until done drops
- done  output  1  one-cycle pulse; s and the flags are valid from this cycle on
- s  output  8  sum (registered; held until the next result)
- cout  output  1  carry out of bit 7
- ov  output  1  signed overflow
- neg  output  1  copy of s[7]
- zero  output  1  high when s == 0

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE immediately, without waiting for a clock edge.
  - busy=0, done=0, s=0x00, cout=0, ov=0, neg=0, zero=1.
  - The internal shift registers, carry flip-flop and bit counter clear to 0.
  - Reset during SOMA aborts the operation; no done is produced.
- IDLE:
  - busy=0.
  - On a clock edge with start=1: latch a into reg_a, b into reg_b, cin into the carry flip-flop, and clear cnt to 0. Go to SOMA.
  - On a clock edge with start=0: remain in IDLE; outputs are held.
- SOMA (8 cycles, busy=1), on each edge:
  - bit = reg_a[0] ^ reg_b[0] ^ carry.
  - carry <= majority(reg_a[0], reg_b[0], carry).
  - reg_a and reg_b shift right.
  - The result shift register shifts right with bit entering at the MSB.
  - cnt <= cnt+1.
  - On the edge where cnt==7 (8th bit, bit 7):
    - record carry-in-to-bit-7 ^ carry-out-of-bit-7 as the overflow value;
    - load s, cout, ov, neg and zero from the completed values;
    - go to FIM.
  - s and the flags do not change during SOMA; they keep the previous result until the FIM load.
- FIM (1 cycle):
  - done=1, busy=1.
  - On the next edge: go to IDLE, done=0, busy=0.
  - start is ignored in FIM. A new request is accepted only in IDLE, so back-to-back issue costs one idle cycle.
- Latency: with start accepted at edge k, done is high during the cycle after edge k+8 and drops at edge k+9. Throughput is one result per 10 cycles.
- start asserted during SOMA or FIM is ignored. Changes to a, b or cin after acceptance have no effect.
- Arithmetic:
  - {cout,s} = a + b + cin, modulo 2^9.
  - ov = (a[7]==b[7]) && (s[7]!=a[7]).
  - neg = s[7].
  - zero = (s==0), independent of cout.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. a=0x05, b=0x03, cin=0, start pulse → done after 9 edges; s=0x08, cout=0, ov=0, neg=0, zero=0. busy is high for exactly 9 cycles.
2. a=0x7F, b=0x01, cin=0 → s=0x80, cout=0, ov=1, neg=1, zero=0.
3. a=0xFF, b=0x01, cin=0 → s=0x00, cout=1, ov=0, neg=0, zero=1. Also a=0xFF, b=0x00, cin=1 → same result.
4. a=0x80, b=0x80, cin=0 → s=0x00, cout=1, ov=1, zero=1. Then a=0xC8 (-56), b=0x14 (+20), cin=0 → s=0xDC (-36), cout=0, ov=0, neg=1, zero=0.
5. Handshake:
   - Start 0x10+0x20.
   - Pulse start with a=0xAA, b=0x55 at cycle 4 of SOMA, and again during FIM.
   - Required: exactly one done, s=0x30. The ignored requests produce no second busy period.
   - start held high continuously → a new operation is accepted on the first IDLE edge after done.
6. Reset:
   - Start 0x7F+0x7F; assert rst asynchronously (between clock edges) at cycle 5 of SOMA.
   - Required: busy=0, done=0, s=0x00 and zero=1 immediately; no done afterwards.
   - After release, 0x01+0x01 → s=0x02.
